logic_op_arbiter: RTL and testbench

//  Shares one registered bitwise logic unit (AND/NAND/OR/NOR/XOR/XNOR/INV) between
//  REQ_N requesters using round-robin arbitration with valid/ready handshakes.

---
 rtl/logic_op_arbiter_pkg.sv | 24 ++
 rtl/logic_op_arbiter_rr_arbiter.sv | 52 +++++
 rtl/logic_op_arbiter.sv | 135 +++++++++++++
 tb/tb_logic_op_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/logic_op_arbiter_pkg.sv
// Shared definitions for the logic-op arbiter: opcode encodings, FSM state codes
// and small helper functions used by the top level.
package logic_op_arbiter_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_AND     = 3'd0;
    localparam logic [OP_W-1:0] OP_NAND    = 3'd1;
    localparam logic [OP_W-1:0] OP_OR      = 3'd2;
    localparam logic [OP_W-1:0] OP_NOR     = 3'd3;
    localparam logic [OP_W-1:0] OP_XOR     = 3'd4;
    localparam logic [OP_W-1:0] OP_XNOR    = 3'd5;
    localparam logic [OP_W-1:0] OP_INV     = 3'd6;
    localparam logic [OP_W-1:0] OP_ILLEGAL = 3'd7;

    // Result slot occupancy: EMPTY means res_valid_o is low.
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    function automatic logic op_is_illegal(input logic [OP_W-1:0] op);
        return (op == OP_ILLEGAL);
    endfunction

endpackage

// File: rtl/logic_op_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first asserted request at or above the pointer,
// wrapping from REQ_N-1 back to 0. Produces a one-hot grant and its binary index.
module rr_arbiter
    import logic_op_arbiter_pkg::*;
#(
    parameter int REQ_N = 4,
    parameter int ID_W  = $clog2(REQ_N)
) (
    input  logic [REQ_N-1:0] req_i,
    input  logic [ID_W-1:0]  ptr_i,
    input  logic             en_i,
    output logic [REQ_N-1:0] gnt_o,
    output logic [ID_W-1:0]  idx_o,
    output logic             any_o
);

    logic [REQ_N-1:0] w_gnt;
    logic [ID_W-1:0]  w_idx;
    logic             w_found;

    // Rotating priority search; the sum is one bit wider so the wrap compare cannot overflow.
    always_comb begin
        logic [ID_W:0]   w_sum;
        logic [ID_W-1:0] w_cand;
        w_gnt   = '0;
        w_idx   = '0;
        w_found = 1'b0;
        w_sum   = '0;
        w_cand  = '0;
        for (int i = 0; i < REQ_N; i++) begin
            w_sum = {1'b0, ptr_i} + (ID_W+1)'(i);
            if (w_sum >= (ID_W+1)'(REQ_N)) begin
                w_sum = w_sum - (ID_W+1)'(REQ_N);
            end else begin
                w_sum = w_sum;
            end
            w_cand = w_sum[ID_W-1:0];
            if (!w_found && req_i[w_cand]) begin
                w_found        = 1'b1;
                w_gnt[w_cand]  = 1'b1;
                w_idx          = w_cand;
            end else begin
                w_found = w_found;
            end
        end
    end

    assign gnt_o = en_i ? w_gnt : '0;
    assign idx_o = w_idx;
    assign any_o = en_i & w_found;

endmodule

// File: rtl/logic_op_arbiter.sv
// Shares one registered bitwise logic unit between REQ_N requesters using
// round-robin arbitration; each result is returned with the issuing requester's ID.
module logic_op_arbiter
    import logic_op_arbiter_pkg::*;
#(
    parameter  int REQ_N = 4,
    parameter  int WIDTH = 8,
    localparam int ID_W  = $clog2(REQ_N)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [REQ_N-1:0]      req_valid_i,
    output logic [REQ_N-1:0]      req_ready_o,
    input  logic [OP_W*REQ_N-1:0] req_op_i,
    input  logic [WIDTH*REQ_N-1:0] req_a_i,
    input  logic [WIDTH*REQ_N-1:0] req_b_i,
    output logic                  res_valid_o,
    input  logic                  res_ready_i,
    output logic [WIDTH-1:0]      res_data_o,
    output logic [ID_W-1:0]       res_id_o,
    output logic                  res_err_o
);

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [ID_W-1:0]  r_ptr;
    logic [ID_W-1:0]  w_ptr_nxt;
    logic [WIDTH-1:0] r_res_data;
    logic [ID_W-1:0]  r_res_id;
    logic             r_res_err;

    logic             w_slot_free;
    logic [REQ_N-1:0] w_gnt;
    logic [ID_W-1:0]  w_idx;
    logic             w_any;
    logic             w_xfer;
    logic [OP_W-1:0]  w_op;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_result;

    // Draining and refilling in the same cycle keeps back-to-back results bubble-free.
    assign w_slot_free = (r_state == ST_EMPTY) || res_ready_i;

    rr_arbiter #(
        .REQ_N (REQ_N),
        .ID_W  (ID_W)
    ) u_rr_arbiter (
        .req_i (req_valid_i),
        .ptr_i (r_ptr),
        .en_i  (w_slot_free),
        .gnt_o (w_gnt),
        .idx_o (w_idx),
        .any_o (w_any)
    );

    // Grants are suppressed while reset is asserted so nothing is handshaken away.
    assign req_ready_o = w_gnt & {REQ_N{rst_ni}};
    assign w_xfer      = w_any & rst_ni;

    assign w_op = req_op_i[int'(w_idx)*OP_W +: OP_W];
    assign w_a  = req_a_i[int'(w_idx)*WIDTH +: WIDTH];
    assign w_b  = req_b_i[int'(w_idx)*WIDTH +: WIDTH];

    // Logic unit; the illegal opcode yields zero and is flagged separately.
    always_comb begin
        w_result = '0;
        case (w_op)
            OP_AND:  w_result = w_a & w_b;
            OP_NAND: w_result = ~(w_a & w_b);
            OP_OR:   w_result = w_a | w_b;
            OP_NOR:  w_result = ~(w_a | w_b);
            OP_XOR:  w_result = w_a ^ w_b;
            OP_XNOR: w_result = ~(w_a ^ w_b);
            OP_INV:  w_result = ~w_a;
            default: w_result = '0;
        endcase
    end

    // Slot occupancy FSM.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_xfer) begin
                    w_state_nxt = ST_FULL;
                end else begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (res_ready_i && !w_xfer) begin
                    w_state_nxt = ST_EMPTY;
                end else begin
                    w_state_nxt = ST_FULL;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // Pointer moves one past the granted requester so it gets lowest priority next.
    always_comb begin
        if (w_idx == ID_W'(REQ_N-1)) begin
            w_ptr_nxt = '0;
        end else begin
            w_ptr_nxt = w_idx + ID_W'(1);
        end
    end

    // Result, ID, error, pointer and state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= ST_EMPTY;
            r_ptr      <= '0;
            r_res_data <= '0;
            r_res_id   <= '0;
            r_res_err  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_xfer) begin
                r_res_data <= w_result;
                r_res_id   <= w_idx;
                r_res_err  <= op_is_illegal(w_op);
                r_ptr      <= w_ptr_nxt;
            end
        end
    end

    assign res_valid_o = (r_state == ST_FULL);
    assign res_data_o  = r_res_data;
    assign res_id_o    = r_res_id;
    assign res_err_o   = r_res_err;

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Directed bench for logic_op_arbiter (REQ_N=4, WIDTH=8): opcode table on requester 0,
// then hand-written reset, round-robin, backpressure, illegal-op and wrap sequences.
module tb_logic_op_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  v;
    logic [3:0]  req_ready;
    logic [11:0] req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        res_valid;
    logic        res_ready;
    logic [7:0]  res_data;
    logic [1:0]  res_id;
    logic        res_err;

    logic [2:0]  op [4];
    logic [7:0]  a  [4];
    logic [7:0]  b  [4];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp;
        logic       err;
    } vec_t;

    vec_t       tbl [8];
    logic [7:0] exp_rr [4];
    logic [3:0] one_hot;

    logic_op_arbiter #(.REQ_N(4), .WIDTH(8)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (v),
        .req_ready_o (req_ready),
        .req_op_i    (req_op),
        .req_a_i     (req_a),
        .req_b_i     (req_b),
        .res_valid_o (res_valid),
        .res_ready_i (res_ready),
        .res_data_o  (res_data),
        .res_id_o    (res_id),
        .res_err_o   (res_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        req_op = '0;
        req_a  = '0;
        req_b  = '0;
        for (int k = 0; k < 4; k++) begin
            req_op[3*k +: 3] = op[k];
            req_a[8*k +: 8]  = a[k];
            req_b[8*k +: 8]  = b[k];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{3'd0, 8'hF0, 8'h3C, 8'h30, 1'b0};
        tbl[1] = '{3'd1, 8'hF0, 8'h3C, 8'hCF, 1'b0};
        tbl[2] = '{3'd2, 8'hF0, 8'h3C, 8'hFC, 1'b0};
        tbl[3] = '{3'd3, 8'hF0, 8'h3C, 8'h03, 1'b0};
        tbl[4] = '{3'd4, 8'hF0, 8'h3C, 8'hCC, 1'b0};
        tbl[5] = '{3'd5, 8'hF0, 8'h3C, 8'h33, 1'b0};
        tbl[6] = '{3'd6, 8'hF0, 8'h3C, 8'h0F, 1'b0};
        tbl[7] = '{3'd7, 8'hF0, 8'h3C, 8'h00, 1'b1};
        exp_rr[0] = 8'h30;
        exp_rr[1] = 8'hAF;
        exp_rr[2] = 8'hA5;
        exp_rr[3] = 8'hC3;
        one_hot   = 4'b0001;

        rst_n     = 1'b0;
        v         = 4'hF;
        res_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            op[k] = 3'd0;
            a[k]  = 8'h00;
            b[k]  = 8'h00;
        end

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_valid", res_valid, 1'b0);
        chk("reset_ready", req_ready, 4'h0);
        chk("reset_data",  res_data,  8'h00);
        chk("reset_id",    res_id,    2'd0);
        chk("reset_err",   res_err,   1'b0);
        rst_n = 1'b1;
        v     = 4'h0;
        @(negedge clk);

        // Opcode table on requester 0, one result per cycle
        for (int i = 0; i < 8; i++) begin
            op[0] = tbl[i].op;
            a[0]  = tbl[i].a;
            b[0]  = tbl[i].b;
            v     = 4'b0001;
            #1;
            chk("tbl_ready", req_ready, 4'b0001);
            @(negedge clk);
            chk("tbl_valid", res_valid, 1'b1);
            chk("tbl_data",  res_data,  tbl[i].exp);
            chk("tbl_id",    res_id,    2'd0);
            chk("tbl_err",   res_err,   tbl[i].err);
        end
        v = 4'h0;
        @(negedge clk);
        chk("tbl_drained", res_valid, 1'b0);

        // Requester operands for the multi-requester sequences
        op[0] = 3'd0; a[0] = 8'hF0; b[0] = 8'h3C;
        op[1] = 3'd2; a[1] = 8'hA5; b[1] = 8'h0F;
        op[2] = 3'd4; a[2] = 8'hFF; b[2] = 8'h5A;
        op[3] = 3'd6; a[3] = 8'h3C; b[3] = 8'hFF;

        // Pointer is 1 here; run two grants then reset mid-stream
        v = 4'hF;
        #1;
        chk("pre_rst_ready1", req_ready, 4'b0010);
        @(negedge clk);
        chk("pre_rst_id1", res_id, 2'd1);
        chk("pre_rst_data1", res_data, exp_rr[1]);
        #1;
        chk("pre_rst_ready2", req_ready, 4'b0100);
        @(negedge clk);
        chk("pre_rst_valid", res_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", res_valid, 1'b0);
        chk("midrst_ready", req_ready, 4'h0);
        chk("midrst_id",    res_id,    2'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Round-robin from index 0, back-to-back
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("rr_grant", req_ready, one_hot << (k % 4));
            if (k > 0) begin
                chk("rr_valid", res_valid, 1'b1);
                chk("rr_id",    res_id,    (k - 1) % 4);
                chk("rr_data",  res_data,  exp_rr[(k - 1) % 4]);
            end
            @(negedge clk);
        end
        chk("rr_last_id",   res_id,   2'd3);
        chk("rr_last_data", res_data, exp_rr[3]);

        // Backpressure for three cycles
        res_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_ready", req_ready, 4'h0);
            chk("bp_valid", res_valid, 1'b1);
            chk("bp_id",    res_id,    2'd3);
            chk("bp_data",  res_data,  exp_rr[3]);
            @(negedge clk);
        end
        res_ready = 1'b1;
        #1;
        chk("bp_release_grant", req_ready, 4'b0001);
        @(negedge clk);
        chk("bp_next_id",   res_id,   2'd0);
        chk("bp_next_data", res_data, exp_rr[0]);
        v = 4'h0;
        @(negedge clk);
        chk("bp_drained", res_valid, 1'b0);

        // Illegal opcode from requester 2, then a legal one clears the error
        op[2] = 3'd7; a[2] = 8'hFF; b[2] = 8'hFF;
        v = 4'b0100;
        #1;
        chk("ill_ready", req_ready, 4'b0100);
        @(negedge clk);
        chk("ill_err",  res_err,  1'b1);
        chk("ill_data", res_data, 8'h00);
        chk("ill_id",   res_id,   2'd2);
        op[2] = 3'd1; a[2] = 8'hF0; b[2] = 8'h3C;
        #1;
        chk("legal_ready", req_ready, 4'b0100);
        @(negedge clk);
        chk("legal_err",  res_err,  1'b0);
        chk("legal_data", res_data, 8'hCF);
        chk("legal_id",   res_id,   2'd2);

        // Pointer is 3: wrap 3 -> 0, requester 1 withdraws before its turn
        op[3] = 3'd5; a[3] = 8'hF0; b[3] = 8'h3C;
        v = 4'b1011;
        #1;
        chk("wrap_grant3", req_ready, 4'b1000);
        @(negedge clk);
        chk("wrap_id3",   res_id,   2'd3);
        chk("wrap_data3", res_data, 8'h33);
        v = 4'b0001;
        #1;
        chk("wrap_grant0", req_ready, 4'b0001);
        @(negedge clk);
        chk("wrap_id0",   res_id,   2'd0);
        chk("wrap_data0", res_data, 8'h30);
        v = 4'h0;
        #1;
        chk("wrap_idle_ready", req_ready, 4'h0);
        @(negedge clk);
        chk("wrap_no_stale_valid", res_valid, 1'b0);
        chk("wrap_id_hold",        res_id,    2'd0);
        @(negedge clk);
        chk("wrap_still_empty", res_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
